arbiter2n1_16bit: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a shared 16-bit 2:1 data path (mux2n1_16bit) and sequences bursts from two masters onto one downstream bus with a valid/ready handshake. It sits in front of a shared 16-bit resource, such as a memory write port or a peripheral bus. It decides which requester drives the bus, holds the grant for a burst, and hands over with no idle cycle. A hold limit bounds starvation.

---
 rtl/arbiter2n1_16bit_pkg.sv | 17 +
 rtl/arbiter2n1_16bit_if.sv | 27 ++
 rtl/arbiter2n1_16bit_mux.sv | 11 +
 rtl/arbiter2n1_16bit.sv | 96 +++++++++
 tb/tb_arbiter2n1_16bit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/arbiter2n1_16bit_pkg.sv
// Shared types and constants for the two-requester round-robin bus arbiter.
package arbiter2n1_16bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int HOLD_MAX_DEFAULT = 8;
    localparam int DATA_W           = 16;

    function automatic int hold_cnt_width(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/arbiter2n1_16bit_if.sv
// Requester/bus bundle between the two masters, the arbiter and the downstream sink.
interface arbiter2n1_16bit_if;
    import arbiter2n1_16bit_pkg::*;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              last0;
    logic              last1;
    logic              bus_ready;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_owner;

    modport master (
        output req0, req1, data0, data1, last0, last1, bus_ready,
        input  gnt0, gnt1, bus_data, bus_valid, bus_owner
    );

    modport slave (
        input  req0, req1, data0, data1, last0, last1, bus_ready,
        output gnt0, gnt1, bus_data, bus_valid, bus_owner
    );
endinterface

// File: rtl/arbiter2n1_16bit_mux.sv
// Plain 16-bit 2:1 data selector; output gating is left to the arbiter.
module mux2n1_16bit
    import arbiter2n1_16bit_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sel,
    output logic [DATA_W-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/arbiter2n1_16bit.sv
// Round-robin arbiter with burst tenure, zero-bubble handover and a hold limit
// that forces handover once the owner has completed HOLD_MAX beats while the other waits.
module arbiter2n1_16bit
    import arbiter2n1_16bit_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_srst,
    arbiter2n1_16bit_if.slave   arb
);
    localparam int CW = hold_cnt_width(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_PRE = CW'(HOLD_MAX - 1);

    arb_state_e      r_state;
    logic            r_prio;
    logic            r_owner;
    logic [CW-1:0]   r_hold;

    logic            w_owning;
    logic            w_cur;
    logic            w_own_req;
    logic            w_own_last;
    logic            w_other_req;
    logic            w_beat;
    logic            w_preempt;
    logic            w_release;
    logic [DATA_W-1:0] w_muxed;

    assign w_owning    = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_cur       = (r_state == ST_OWN1);
    assign w_own_req   = w_owning & (w_cur ? arb.req1 : arb.req0);
    assign w_own_last  = w_cur ? arb.last1 : arb.last0;
    assign w_other_req = w_cur ? arb.req0 : arb.req1;
    assign w_beat      = w_own_req & arb.bus_ready;

    // Look ahead by one beat so the tenure ends on the HOLD_MAX-th beat itself
    // rather than granting one extra beat after the counter saturates.
    assign w_preempt = w_other_req & ((r_hold == HOLD_LIM) | (w_beat & (r_hold == HOLD_PRE)));
    assign w_release = w_owning & ((w_beat & w_own_last) | ~w_own_req | w_preempt);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold <= '0;
                    if (arb.req0 && (!arb.req1 || !r_prio)) begin
                        r_state <= ST_OWN0;
                        r_owner <= 1'b0;
                    end else if (arb.req1) begin
                        r_state <= ST_OWN1;
                        r_owner <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_release) begin
                        r_prio <= ~w_cur;
                        r_hold <= '0;
                        if (w_other_req) begin
                            r_state <= w_cur ? ST_OWN0 : ST_OWN1;
                            r_owner <= ~w_cur;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_beat && (r_hold != HOLD_LIM)) begin
                        r_hold <= r_hold + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    mux2n1_16bit u_mux (
        .i_a   (arb.data0),
        .i_b   (arb.data1),
        .i_sel (w_cur),
        .o_y   (w_muxed)
    );

    assign arb.gnt0      = (r_state == ST_OWN0);
    assign arb.gnt1      = (r_state == ST_OWN1);
    assign arb.bus_valid = w_own_req;
    assign arb.bus_data  = w_owning ? w_muxed : '0;
    assign arb.bus_owner = r_owner;

endmodule

// File: tb/tb_arbiter2n1_16bit.sv
// Directed bench: a vector table for grant/data sequencing plus hand-written
// sequences for hold-limit preemption, ready stalls, reset and abandoned bursts.
module tb_arbiter2n1_16bit;
    logic clk;
    logic srst;
    int   n_cmp;
    int   n_err;

    arbiter2n1_16bit_if arb ();

    arbiter2n1_16bit #(.HOLD_MAX(8)) dut (
        .i_clk  (clk),
        .i_srst (srst),
        .arb    (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        srst;
        logic        r0;
        logic        r1;
        logic        l0;
        logic        l1;
        logic        rdy;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        g0;
        logic        g1;
        logic        v;
        logic        own;
        logic [15:0] bd;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic s, input logic r0, input logic r1,
                                input logic l0, input logic l1, input logic rdy,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic g0, input logic g1, input logic v,
                                input logic own, input logic [15:0] bd);
        vec_t t;
        t.srst = s;  t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1; t.rdy = rdy;
        t.d0 = d0;   t.d1 = d1; t.g0 = g0; t.g1 = g1; t.v = v;   t.own = own;
        t.bd = bd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                         input logic rdy, input logic [15:0] d0, input logic [15:0] d1);
        arb.req0 = r0; arb.req1 = r1; arb.last0 = l0; arb.last1 = l1;
        arb.bus_ready = rdy; arb.data0 = d0; arb.data1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        next_cycle();
        srst = 1'b0;
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        srst  = 1'b1;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        repeat (2) next_cycle();
        #2;
        chk("rst_gnt0",  {15'd0, arb.gnt0}, 16'd0);
        chk("rst_gnt1",  {15'd0, arb.gnt1}, 16'd0);
        chk("rst_valid", {15'd0, arb.bus_valid}, 16'd0);
        chk("rst_data",  arb.bus_data, 16'h0000);
        chk("rst_owner", {15'd0, arb.bus_owner}, 16'd0);
        srst = 1'b0;
        next_cycle();

        //              s  r0 r1 l0 l1 rdy d0        d1        g0 g1 v  own bd
        vecs[0]  = mk(0, 1, 0, 0, 0, 1, 16'h1111, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[1]  = mk(0, 1, 0, 0, 0, 1, 16'h1111, 16'h0000, 1, 0, 1, 0, 16'h1111);
        vecs[2]  = mk(0, 1, 0, 0, 0, 1, 16'h2222, 16'h0000, 1, 0, 1, 0, 16'h2222);
        vecs[3]  = mk(0, 1, 0, 1, 0, 1, 16'h3333, 16'h0000, 1, 0, 1, 0, 16'h3333);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 16'h3333, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[5]  = mk(0, 1, 1, 0, 0, 1, 16'h4444, 16'h5555, 0, 0, 0, 0, 16'h0000);
        vecs[6]  = mk(0, 1, 1, 0, 1, 1, 16'h4444, 16'h5555, 0, 1, 1, 1, 16'h5555);
        vecs[7]  = mk(0, 1, 0, 0, 0, 1, 16'h4444, 16'h5555, 1, 0, 1, 0, 16'h4444);
        vecs[8]  = mk(1, 1, 0, 0, 0, 1, 16'h4444, 16'h5555, 1, 0, 1, 0, 16'h4444);
        vecs[9]  = mk(0, 1, 1, 0, 0, 1, 16'hAAAA, 16'hBBBB, 0, 0, 0, 0, 16'h0000);
        vecs[10] = mk(0, 1, 1, 1, 0, 1, 16'hAAAA, 16'hBBBB, 1, 0, 1, 0, 16'hAAAA);
        vecs[11] = mk(0, 0, 1, 0, 0, 1, 16'hAAAA, 16'hBBBB, 0, 1, 1, 1, 16'hBBBB);
        vecs[12] = mk(0, 1, 1, 0, 1, 0, 16'hAAAA, 16'hBBB1, 0, 1, 1, 1, 16'hBBB1);
        vecs[13] = mk(0, 1, 1, 0, 1, 1, 16'hAAAA, 16'hBBB1, 0, 1, 1, 1, 16'hBBB1);
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 16'hCCCC, 16'hBBB1, 1, 0, 1, 0, 16'hCCCC);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 16'hCCCC, 16'hBBB1, 1, 0, 0, 0, 16'hCCCC);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 16'hCCCC, 16'hBBB1, 0, 0, 0, 0, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            srst = vecs[i].srst;
            drive(vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1, vecs[i].rdy,
                  vecs[i].d0, vecs[i].d1);
            #2;
            $display("vec %0d: gnt=%b%b valid=%b owner=%b data=%h", i,
                     arb.gnt1, arb.gnt0, arb.bus_valid, arb.bus_owner, arb.bus_data);
            chk($sformatf("vec%0d_gnt0", i),  {15'd0, arb.gnt0},      {15'd0, vecs[i].g0});
            chk($sformatf("vec%0d_gnt1", i),  {15'd0, arb.gnt1},      {15'd0, vecs[i].g1});
            chk($sformatf("vec%0d_valid", i), {15'd0, arb.bus_valid}, {15'd0, vecs[i].v});
            chk($sformatf("vec%0d_owner", i), {15'd0, arb.bus_owner}, {15'd0, vecs[i].own});
            chk($sformatf("vec%0d_data", i),  arb.bus_data,           vecs[i].bd);
            next_cycle();
        end
        srst = 1'b0;

        // Hold limit: owner 0 streams with no Last while requester 1 waits.
        do_reset();
        drive(1, 1, 0, 0, 1, 16'h0100, 16'h0200);
        next_cycle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!arb.gnt0) break;
            n++;
            next_cycle();
        end
        $display("hold: owner0 beats before handover = %0d", n);
        chk("hold_beats", 16'(n), 16'd8);
        chk("hold_gnt1",  {15'd0, arb.gnt1}, 16'd1);
        chk("hold_data",  arb.bus_data, 16'h0200);

        // Same stream with requester 1 absent: tenure is never cut.
        do_reset();
        drive(1, 0, 0, 0, 1, 16'h0300, 16'h0000);
        next_cycle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (arb.gnt0 && arb.bus_valid) n++;
            next_cycle();
        end
        $display("solo: owner0 granted beats = %0d", n);
        chk("solo_beats", 16'(n), 16'd20);

        // Last0 stalled by BusReady=0 for 4 cycles.
        do_reset();
        drive(1, 0, 0, 0, 1, 16'h0001, 16'h0000);
        next_cycle();
        drive(1, 0, 1, 0, 0, 16'hDEAD, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            #2;
            $display("stall %0d: gnt0=%b data=%h", i, arb.gnt0, arb.bus_data);
            chk($sformatf("stall%0d_gnt0", i), {15'd0, arb.gnt0}, 16'd1);
            chk($sformatf("stall%0d_data", i), arb.bus_data, 16'hDEAD);
            next_cycle();
        end
        arb.bus_ready = 1'b1;
        #2;
        chk("stall_last_gnt0", {15'd0, arb.gnt0}, 16'd1);
        next_cycle();
        arb.req0 = 1'b0;
        #2;
        $display("stall release: gnt0=%b", arb.gnt0);
        chk("stall_rel_gnt0", {15'd0, arb.gnt0}, 16'd0);

        // Reset pulsed mid-burst in OWN1.
        do_reset();
        drive(0, 1, 0, 0, 1, 16'h0000, 16'h7777);
        next_cycle();
        next_cycle();
        #2;
        chk("mid_gnt1_pre", {15'd0, arb.gnt1}, 16'd1);
        srst = 1'b1;
        next_cycle();
        srst = 1'b0;
        arb.req0 = 1'b1;
        #2;
        $display("mid reset: gnt=%b%b valid=%b data=%h", arb.gnt1, arb.gnt0,
                 arb.bus_valid, arb.bus_data);
        chk("mid_gnt0",  {15'd0, arb.gnt0}, 16'd0);
        chk("mid_gnt1",  {15'd0, arb.gnt1}, 16'd0);
        chk("mid_valid", {15'd0, arb.bus_valid}, 16'd0);
        chk("mid_data",  arb.bus_data, 16'h0000);
        next_cycle();
        #2;
        chk("mid_prio0", {15'd0, arb.gnt0}, 16'd1);

        // Owner drops Req without Last: other requester taken over at once, then IDLE.
        do_reset();
        drive(1, 1, 0, 0, 1, 16'h0A0A, 16'h0B0B);
        next_cycle();
        arb.req0 = 1'b0;
        #2;
        chk("drop_gnt0", {15'd0, arb.gnt0}, 16'd1);
        next_cycle();
        #2;
        chk("drop_gnt1", {15'd0, arb.gnt1}, 16'd1);
        arb.req1 = 1'b0;
        next_cycle();
        #2;
        $display("drop idle: gnt=%b%b owner=%b", arb.gnt1, arb.gnt0, arb.bus_owner);
        chk("drop_idle", {14'd0, arb.gnt1, arb.gnt0}, 16'd0);
        chk("drop_owner_held", {15'd0, arb.bus_owner}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
